// File: rtl/bus_burst_responder.sv
// Burst-bus target: on-chip word RAM at BASE_ADDRESS with single/burst read and write,
// out-of-window burst error, and a read-only local back-door port.
//
// state      | meaning
// IDLE       | waiting for a selected begin strobe
// WRITE      | accepting write words until the initiator ends
// READ_FETCH | one cycle of RAM latency before the first read word
// READ       | presenting one read word per cycle
// READ_END   | end-of-transaction strobe on the bus
// ERROR      | bus error strobe on the bus
module bus_burst_responder #(
   parameter logic [31:0] BASE_ADDRESS    = 32'h5000_0000,
   parameter int          ADDR_WORDS_LOG2 = 9
) (
   input  logic                       clock,
   input  logic                       nReset,
   input  logic                       beginTransactionIn,
   input  logic [31:0]                addressDataIn,
   input  logic [7:0]                 burstSizeIn,
   input  logic                       readNotWriteIn,
   input  logic                       dataValidIn,
   input  logic                       endTransactionIn,
   output logic [31:0]                addressDataOut,
   output logic                       dataValidOut,
   output logic                       endTransactionOut,
   output logic                       busErrorOut,
   input  logic [ADDR_WORDS_LOG2-1:0] localAddress,
   output logic [31:0]                localData
);

   localparam int AW    = ADDR_WORDS_LOG2;
   localparam int DEPTH = 1 << AW;
   localparam int CNT_W = 9;
   localparam int SUM_W = (AW + 1 > 9) ? AW + 1 : 9;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_FETCH,
      READ,
      READ_END,
      ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_d, end_d, err_d;
   logic              rd_en, wr_en;
   logic              sel;
   logic              overflow;
   logic [AW-1:0]     begin_idx;
   logic [SUM_W-1:0]  last_idx;
   logic [31:0]       mem [DEPTH];

   assign sel       = addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2];
   assign begin_idx = addressDataIn[AW+1:2];
   // widened so a burst running off the top of the window cannot wrap back in
   assign last_idx  = SUM_W'(begin_idx) + SUM_W'(burstSizeIn);
   assign overflow  = last_idx > SUM_W'(DEPTH - 1);

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts words still to be moved; zero is the terminal count
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (beginTransactionIn && sel) begin
               ptr_d = begin_idx;
               cnt_d = CNT_W'(burstSizeIn) + CNT_W'(1);
               if (overflow) begin
                  err_d   = 1'b1;
                  state_d = ERROR;
               end else if (readNotWriteIn) begin
                  state_d = READ_FETCH;
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (dataValidIn && cnt_q != '0) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + AW'(1);
               cnt_d = cnt_q - CNT_W'(1);
            end
            if (endTransactionIn) state_d = IDLE;
         end
         READ_FETCH: begin
            if (endTransactionIn) begin
               state_d = IDLE;
            end else begin
               rd_en   = 1'b1;
               valid_d = 1'b1;
               ptr_d   = ptr_q + AW'(1);
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = READ;
            end
         end
         READ: begin
            if (endTransactionIn) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               end_d   = 1'b1;
               state_d = READ_END;
            end else begin
               rd_en   = 1'b1;
               valid_d = 1'b1;
               ptr_d   = ptr_q + AW'(1);
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         READ_END: state_d = IDLE;
         ERROR:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         addressDataOut    <= '0;
         dataValidOut      <= 1'b0;
         endTransactionOut <= 1'b0;
         busErrorOut       <= 1'b0;
      end else begin
         addressDataOut    <= rd_en ? mem[ptr_q] : '0;
         dataValidOut      <= valid_d;
         endTransactionOut <= end_d;
         busErrorOut       <= err_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clock) begin
      if (wr_en) mem[ptr_q] <= addressDataIn;
   end

   // back-door port sees the pre-write word on a same-cycle collision
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) localData <= '0;
      else         localData <= mem[localAddress];
   end

endmodule

// File: tb/tb_bus_burst_responder.sv
// Randomized scoreboard bench for bus_burst_responder: a word-array model of the RAM
// predicts read data and strobes; a negedge monitor pops and compares.
module tb_bus_burst_responder;

   localparam logic [31:0] BASE  = 32'h5000_0000;
   localparam int          AW    = 9;
   localparam int          DEPTH = 512;

   logic          clock = 1'b0;
   logic          nReset;
   logic          beginTransactionIn;
   logic [31:0]   addressDataIn;
   logic [7:0]    burstSizeIn;
   logic          readNotWriteIn;
   logic          dataValidIn;
   logic          endTransactionIn;
   logic [31:0]   addressDataOut;
   logic          dataValidOut;
   logic          endTransactionOut;
   logic          busErrorOut;
   logic [AW-1:0] localAddress;
   logic [31:0]   localData;

   bus_burst_responder #(.BASE_ADDRESS(BASE), .ADDR_WORDS_LOG2(AW)) dut (
      .clock              (clock),
      .nReset             (nReset),
      .beginTransactionIn (beginTransactionIn),
      .addressDataIn      (addressDataIn),
      .burstSizeIn        (burstSizeIn),
      .readNotWriteIn     (readNotWriteIn),
      .dataValidIn        (dataValidIn),
      .endTransactionIn   (endTransactionIn),
      .addressDataOut     (addressDataOut),
      .dataValidOut       (dataValidOut),
      .endTransactionOut  (endTransactionOut),
      .busErrorOut        (busErrorOut),
      .localAddress       (localAddress),
      .localData          (localData)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          passes = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_rd [$];
   int          pend_end = 0;
   int          pend_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >> (AW + 2)) == (BASE >> (AW + 2));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // monitor: every bus strobe must have been predicted by the stimulus side
   always @(negedge clock) begin
      if (nReset) begin
         if (dataValidOut) begin
            chk("valid_expected", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) chk("read_data", addressDataOut, exp_rd.pop_front());
         end else begin
            chk("idle_bus_zero", addressDataOut, 0);
         end
         if (endTransactionOut) begin
            chk("end_expected", pend_end > 0, 1);
            if (pend_end > 0) pend_end--;
         end
         if (busErrorOut) begin
            chk("err_expected", pend_err > 0, 1);
            if (pend_err > 0) pend_err--;
         end
      end
   end

   task automatic start(input logic [31:0] addr, input int burst, input bit rnw);
      beginTransactionIn = 1'b1;
      addressDataIn      = addr;
      burstSizeIn        = 8'(burst);
      readNotWriteIn     = rnw;
      tick();
      beginTransactionIn = 1'b0;
      burstSizeIn        = 8'd0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input int burst, input logic [31:0] words[$],
                            input bit gaps, input bit late_end);
      bit ok  = in_window(addr) && (widx(addr) + burst <= DEPTH - 1);
      bit err = in_window(addr) && !ok;
      int idx = widx(addr);
      if (err) pend_err++;
      start(addr, burst, 1'b0);
      if (err) begin
         chk("wr_err_plus1", busErrorOut, 1);
         tick();
         chk("wr_err_plus2", busErrorOut, 0);
      end
      for (int i = 0; i < words.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            dataValidIn   = 1'b0;
            addressDataIn = $urandom;
            tick();
         end
         dataValidIn      = 1'b1;
         addressDataIn    = words[i];
         endTransactionIn = (i == words.size() - 1) && !late_end;
         if (ok && i <= burst) model_mem[idx + i] = words[i];
         tick();
      end
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
      if (late_end) begin
         endTransactionIn = 1'b1;
         tick();
         endTransactionIn = 1'b0;
      end
   endtask

   task automatic bus_read(input logic [31:0] addr, input int burst, input int abort_at);
      bit ok    = in_window(addr) && (widx(addr) + burst <= DEPTH - 1);
      bit err   = in_window(addr) && !ok;
      bit abort = abort_at >= 0 && abort_at <= burst;
      int n     = abort ? abort_at + 1 : burst + 1;
      if (err) pend_err++;
      if (ok) begin
         for (int j = 0; j < n; j++) exp_rd.push_back(model_mem[widx(addr) + j]);
         if (!abort) pend_end++;
      end
      start(addr, burst, 1'b1);
      if (err) begin
         chk("rd_err_plus1", busErrorOut, 1);
         tick();
         chk("rd_err_plus2", busErrorOut, 0);
         return;
      end
      if (!ok) begin
         for (int k = 0; k < 4; k++) tick();
         return;
      end
      chk("fetch_silent", dataValidOut, 0);
      tick();
      chk("first_word_latency", dataValidOut, 1);
      for (int j = 0; j < n; j++) begin
         if (abort && j == abort_at) endTransactionIn = 1'b1;
         tick();
         endTransactionIn = 1'b0;
      end
      if (abort) begin
         chk("abort_valid_low", dataValidOut, 0);
         chk("abort_data_zero", addressDataOut, 0);
         chk("abort_no_end", endTransactionOut, 0);
         tick();
         chk("abort_no_end_late", endTransactionOut, 0);
      end else begin
         chk("end_after_last", endTransactionOut, 1);
         chk("end_data_zero", addressDataOut, 0);
         chk("end_valid_low", dataValidOut, 0);
         tick();
         chk("end_single", endTransactionOut, 0);
      end
   endtask

   task automatic check_local(input int idx);
      localAddress = AW'(idx);
      tick();
      chk("local_data", localData, model_mem[idx]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] q [$];
      logic [31:0] old_w;
      logic [31:0] a;
      int          burst;

      nReset = 1'b0;
      beginTransactionIn = 1'b0; addressDataIn = '0; burstSizeIn = '0;
      readNotWriteIn = 1'b0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
      localAddress = '0;
      #3;
      chk("reset_valid", dataValidOut, 0);
      chk("reset_data", addressDataOut, 0);
      chk("reset_end", endTransactionOut, 0);
      chk("reset_err", busErrorOut, 0);
      #10 nReset = 1'b1;
      tick();

      // fill the whole RAM so the model is fully known
      for (int h = 0; h < 2; h++) begin
         q.delete();
         for (int i = 0; i < 256; i++) q.push_back($urandom);
         bus_write(BASE + 32'(h * 1024), 255, q, 1'b0, 1'b0);
      end
      check_local(0);
      check_local(511);

      // directed write of 1..4 at word 4 with a same-cycle back-door read of word 4
      old_w = model_mem[4];
      localAddress = AW'(4);
      start(BASE + 32'h10, 3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         dataValidIn      = 1'b1;
         addressDataIn    = 32'(i + 1);
         endTransactionIn = (i == 3);
         tick();
         if (i == 0) chk("local_read_before_write", localData, old_w);
         model_mem[4 + i] = 32'(i + 1);
      end
      dataValidIn = 1'b0; endTransactionIn = 1'b0;
      for (int i = 4; i < 8; i++) check_local(i);

      bus_read(BASE + 32'h10, 3, -1);

      // burst crossing the top of the window
      q.delete(); q.push_back(32'hDEAD_0001); q.push_back(32'hDEAD_0002);
      bus_write(BASE + 32'h7FC, 1, q, 1'b0, 1'b0);
      check_local(511);
      check_local(0);
      bus_read(BASE + 32'h7FC, 1, -1);
      bus_read(BASE + 32'h7F8, 1, -1);

      // outside the window
      q.delete(); for (int i = 0; i < 4; i++) q.push_back(32'hBAD0_0000 + 32'(i));
      bus_write(32'h4000_0010, 3, q, 1'b0, 1'b0);
      bus_read(32'h4000_0010, 3, -1);
      for (int i = 4; i < 8; i++) check_local(i);

      // aborted long read, then a new begin two cycles after the abort
      bus_read(BASE + 32'h100, 15, 2);
      bus_read(BASE + 32'h200, 0, -1);

      // extra words beyond the burst length are dropped
      q.delete(); for (int i = 0; i < 5; i++) q.push_back($urandom);
      bus_write(BASE + 32'h300, 1, q, 1'b1, 1'b1);
      for (int i = 192; i < 197; i++) check_local(i);

      // reset in the middle of a write burst
      localAddress = AW'(16);
      start(BASE + 32'h40, 7, 1'b0);
      for (int i = 0; i < 3; i++) begin
         dataValidIn   = 1'b1;
         addressDataIn = 32'hA000_0000 + 32'(i + 1);
         model_mem[16 + i] = addressDataIn;
         tick();
      end
      dataValidIn = 1'b0;
      tick();
      #2 nReset = 1'b0;
      #1;
      chk("rst_async_valid", dataValidOut, 0);
      chk("rst_async_data", addressDataOut, 0);
      chk("rst_async_local", localData, 0);
      tick();
      #2 nReset = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         dataValidIn   = 1'b1;
         addressDataIn = 32'hFFFF_0000 + 32'(i);
         tick();
      end
      dataValidIn = 1'b0;
      for (int i = 16; i < 24; i++) check_local(i);
      bus_read(BASE + 32'h40, 7, -1);

      // randomized mix of reads, writes, errors and unselected begins
      for (int t = 0; t < 150; t++) begin
         int kind = $urandom_range(0, 9);
         burst = $urandom_range(0, 20);
         if (kind < 8) begin
            a = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
         end else if (kind == 8) begin
            a = BASE + ($urandom_range(DEPTH - 12, DEPTH - 1) << 2);
         end else begin
            a = $urandom;
            if (in_window(a)) a[31] = ~a[31];
         end
         if ($urandom_range(0, 1) == 1) begin
            bus_read(a, burst, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, burst)) : -1);
         end else begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, burst + 3)); i++) q.push_back($urandom);
            bus_write(a, burst, q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         check_local($urandom_range(0, DEPTH - 1));
      end

      for (int k = 0; k < 4; k++) tick();
      chk("scoreboard_drained", exp_rd.size(), 0);
      chk("end_strobes_seen", pend_end, 0);
      chk("err_strobes_seen", pend_err, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
